// File: rtl/fare_account_responder.sv
// Account-side responder: looks up tapped cards, reports status and debits one fare on request.
// Define FARE_AUDIT_EN to add the debit_count/revenue audit outputs.
module fare_account_responder #(
    parameter int NUM_CARDS     = 16,
    parameter int ID_W          = 4,
    parameter int BAL_W         = 16,
    parameter int FARE          = 315,
    parameter int LOOKUP_CYCLES = 2,
    parameter int DEBIT_TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [ID_W-1:0]  req_id,
    output logic             busy,
    output logic             resp_valid,
    output logic             card_active,
    output logic             fund_enough,
    input  logic             reduce_bal,
    output logic             debit_done,
    output logic [BAL_W-1:0] balance_out,
`ifdef FARE_AUDIT_EN
    output logic [15:0]      debit_count,
    output logic [31:0]      revenue,
`endif
    input  logic             acct_wr_en,
    input  logic [ID_W-1:0]  acct_wr_id,
    input  logic             acct_wr_active,
    input  logic [BAL_W-1:0] acct_wr_bal
);

    localparam int CNT_MAX = (LOOKUP_CYCLES > DEBIT_TIMEOUT) ? LOOKUP_CYCLES : DEBIT_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] LOOKUP_LOAD  = CNT_W'(LOOKUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(DEBIT_TIMEOUT - 1);
    localparam logic [BAL_W-1:0] FARE_AMT     = BAL_W'(FARE);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        RESPOND,
        WAIT_DEBIT,
        DEBIT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [ID_W-1:0]  cur_id;

    logic             tbl_active [NUM_CARDS];
    logic [BAL_W-1:0] tbl_bal    [NUM_CARDS];

    logic             cur_ok;
    logic             cur_act;
    logic [BAL_W-1:0] cur_bal;
    logic [BAL_W-1:0] cur_taken;

    function automatic logic in_range(input logic [ID_W-1:0] id);
        int idx;
        idx = int'(id);
        return idx < NUM_CARDS;
    endfunction

    // Amount actually removed by one debit: the full fare, or whatever is left.
    function automatic logic [BAL_W-1:0] fare_taken(input logic [BAL_W-1:0] bal);
        return (bal >= FARE_AMT) ? FARE_AMT : bal;
    endfunction

    always_comb begin
        cur_ok  = in_range(cur_id);
        cur_act = 1'b0;
        cur_bal = '0;
        if (cur_ok) begin
            cur_act = tbl_active[cur_id];
            cur_bal = tbl_bal[cur_id];
        end
        cur_taken = fare_taken(cur_bal);
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            cur_id      <= '0;
            resp_valid  <= 1'b0;
            card_active <= 1'b0;
            fund_enough <= 1'b0;
            debit_done  <= 1'b0;
            balance_out <= '0;
            for (int i = 0; i < NUM_CARDS; i++) begin
                tbl_active[i] <= 1'b0;
                tbl_bal[i]    <= '0;
            end
`ifdef FARE_AUDIT_EN
            debit_count <= '0;
            revenue     <= '0;
`endif
        end else begin
            resp_valid <= 1'b0;
            debit_done <= 1'b0;

            if (acct_wr_en && in_range(acct_wr_id)) begin
                tbl_active[acct_wr_id] <= acct_wr_active;
                tbl_bal[acct_wr_id]    <= acct_wr_bal;
            end

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cur_id <= req_id;
                        cnt    <= LOOKUP_LOAD;
                        state  <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (cnt == '0) state <= RESPOND;
                    else           cnt   <= cnt - 1'b1;
                end
                RESPOND: begin
                    resp_valid  <= 1'b1;
                    card_active <= cur_act;
                    fund_enough <= cur_act && (cur_bal >= FARE_AMT);
                    balance_out <= cur_bal;
                    cnt         <= TIMEOUT_LOAD;
                    state       <= (cur_act && (cur_bal >= FARE_AMT)) ? WAIT_DEBIT : IDLE;
                end
                WAIT_DEBIT: begin
                    if (reduce_bal)      state <= DEBIT;
                    else if (cnt == '0)  state <= IDLE;
                    else                 cnt   <= cnt - 1'b1;
                end
                DEBIT: begin
                    state <= IDLE;
                    // A same-cycle admin write to this card overrides the debit entirely.
                    if (acct_wr_en && (acct_wr_id == cur_id)) begin
                        balance_out <= acct_wr_bal;
                    end else begin
                        tbl_bal[cur_id] <= cur_bal - cur_taken;
                        balance_out     <= cur_bal - cur_taken;
                        debit_done      <= 1'b1;
`ifdef FARE_AUDIT_EN
                        debit_count <= debit_count + 16'd1;
                        revenue     <= revenue + 32'(cur_taken);
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fare_account_responder.sv
// Directed bench for fare_account_responder with a timestamp-based account model checked every cycle.
module tb_fare_account_responder;

    localparam int NC   = 12;
    localparam int L    = 2;
    localparam int T    = 8;
    localparam int FARE = 315;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [3:0]  req_id = '0;
    logic        busy, resp_valid, card_active, fund_enough, debit_done;
    logic        reduce_bal = 1'b0;
    logic [15:0] balance_out;
    logic        acct_wr_en = 1'b0;
    logic [3:0]  acct_wr_id = '0;
    logic        acct_wr_active = 1'b0;
    logic [15:0] acct_wr_bal = '0;
`ifdef FARE_AUDIT_EN
    logic [15:0] debit_count;
    logic [31:0] revenue;
`endif

    always #5 clk = ~clk;

    fare_account_responder #(
        .NUM_CARDS(NC), .ID_W(4), .BAL_W(16), .FARE(FARE),
        .LOOKUP_CYCLES(L), .DEBIT_TIMEOUT(T)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_id(req_id), .busy(busy),
        .resp_valid(resp_valid), .card_active(card_active), .fund_enough(fund_enough),
        .reduce_bal(reduce_bal), .debit_done(debit_done), .balance_out(balance_out),
`ifdef FARE_AUDIT_EN
        .debit_count(debit_count), .revenue(revenue),
`endif
        .acct_wr_en(acct_wr_en), .acct_wr_id(acct_wr_id),
        .acct_wr_active(acct_wr_active), .acct_wr_bal(acct_wr_bal)
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // Model: events are scheduled by edge number rather than by FSM state.
    int   cyc = 0;
    int   free_at = 0;
    int   resp_at = -1;
    int   win_start = -1;
    int   win_end = -1;
    int   debit_at = -1;
    int   m_id = 0;
    bit   m_act [16];
    int   m_bal [16];
    bit   e_rv = 0, e_ca = 0, e_fe = 0, e_dd = 0, e_busy = 0;
    int   e_bo = 0;
    int   e_cnt = 0;
    logic [31:0] e_rev = '0;

    always @(posedge clk) begin
        int ded;
        cyc++;
        e_rv = 0;
        e_dd = 0;
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                m_act[i] = 0;
                m_bal[i] = 0;
            end
            free_at = 0; resp_at = -1; win_start = -1; win_end = -1; debit_at = -1;
            m_id = 0; e_ca = 0; e_fe = 0; e_bo = 0; e_cnt = 0; e_rev = '0;
        end else begin
            if (cyc == debit_at) begin
                if (acct_wr_en && int'(acct_wr_id) == m_id) begin
                    e_bo = int'(acct_wr_bal);
                end else begin
                    ded = (m_bal[m_id] >= FARE) ? FARE : m_bal[m_id];
                    m_bal[m_id] = m_bal[m_id] - ded;
                    e_bo  = m_bal[m_id];
                    e_dd  = 1;
                    e_cnt = (e_cnt + 1) % 65536;
                    e_rev = e_rev + 32'(ded);
                end
                debit_at = -1;
            end
            if (reduce_bal && cyc >= win_start && cyc <= win_end) begin
                debit_at = cyc + 1;
                free_at  = cyc + 2;
                win_end  = -1;
            end
            if (cyc == resp_at) begin
                e_rv = 1;
                e_ca = (m_id < NC) && m_act[m_id];
                e_fe = e_ca && (m_bal[m_id] >= FARE);
                e_bo = (m_id < NC) ? m_bal[m_id] : 0;
                if (e_fe) begin
                    win_start = cyc + 1;
                    win_end   = cyc + T;
                    free_at   = cyc + T + 1;
                end
                resp_at = -1;
            end
            if (req_valid && cyc >= free_at) begin
                m_id    = int'(req_id);
                resp_at = cyc + L + 1;
                free_at = cyc + L + 2;
            end
            if (acct_wr_en && int'(acct_wr_id) < NC) begin
                m_act[acct_wr_id] = acct_wr_active;
                m_bal[acct_wr_id] = int'(acct_wr_bal);
            end
        end
        e_busy = (free_at > cyc + 1);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("resp_valid",  resp_valid,  e_rv);
            chk("card_active", card_active, e_ca);
            chk("fund_enough", fund_enough, e_fe);
            chk("debit_done",  debit_done,  e_dd);
            chk("busy",        busy,        e_busy);
            chk("balance_out", balance_out, e_bo);
`ifdef FARE_AUDIT_EN
            chk("debit_count", debit_count, e_cnt);
            chk("revenue",     revenue,     e_rev);
`endif
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic admin(input int id, input bit act, input int bal);
        acct_wr_en = 1'b1; acct_wr_id = 4'(id); acct_wr_active = act; acct_wr_bal = 16'(bal);
        tick(1);
        acct_wr_en = 1'b0;
    endtask

    task automatic tap(input int id);
        req_valid = 1'b1; req_id = 4'(id);
        tick(1);
        req_valid = 1'b0;
    endtask

    task automatic pulse_reduce();
        reduce_bal = 1'b1;
        tick(1);
        reduce_bal = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_bo", balance_out, 0);
        chk("rst_busy", busy, 0);

        // Funded card: response three edges after the tap, then a full fare debit.
        admin(3, 1, 1000);
        tap(3);
        tick(2);
        chk("t1_busy", busy, 1);
        tick(1);
        chk("t1_rv", resp_valid, 1);
        chk("t1_ca", card_active, 1);
        chk("t1_fe", fund_enough, 1);
        chk("t1_bo", balance_out, 1000);
        pulse_reduce();
        tick(1);
        chk("t1_dd", debit_done, 1);
        chk("t1_bo_after", balance_out, 685);

        // Unknown card, stray reduce_bal, and an id beyond the table.
        tap(5);
        tick(3);
        chk("t2_ca", card_active, 0);
        chk("t2_fe", fund_enough, 0);
        tick(1);
        chk("t2_idle", busy, 0);
        pulse_reduce();
        tick(1);
        chk("t2_dd", debit_done, 0);
        admin(13, 1, 900);
        tap(13);
        tick(3);
        chk("t2_oor_ca", card_active, 0);
        chk("t2_oor_bo", balance_out, 0);

        // Active but short of a fare.
        admin(7, 1, 300);
        tap(7);
        tick(3);
        chk("t3_ca", card_active, 1);
        chk("t3_fe", fund_enough, 0);
        chk("t3_bo", balance_out, 300);
        tick(1);
        chk("t3_idle", busy, 0);

        // Dropped second tap, timeout, then a debit on the last window cycle.
        req_valid = 1'b1; req_id = 4'd3;
        tick(1);
        req_id = 4'd5;
        tick(1);
        req_valid = 1'b0;
        tick(2);
        chk("t4_rv", resp_valid, 1);
        chk("t4_bo", balance_out, 685);
        tick(7);
        chk("t4_wait", busy, 1);
        tick(1);
        chk("t4_timeout", busy, 0);
        tap(3);
        tick(3);
        chk("t4_bo2", balance_out, 685);
        tick(7);
        pulse_reduce();
        tick(1);
        chk("t4_late_dd", debit_done, 1);
        chk("t4_late_bo", balance_out, 370);

        // Admin lowers balance mid-wait, then admin write collides with DEBIT.
        tap(3);
        tick(3);
        admin(3, 1, 100);
        pulse_reduce();
        tick(1);
        chk("t5_dd", debit_done, 1);
        chk("t5_sat", balance_out, 0);
        admin(3, 1, 1000);
        tap(3);
        tick(3);
        reduce_bal = 1'b1;
        tick(1);
        reduce_bal = 1'b0;
        admin(3, 1, 50);
        chk("t5_col_dd", debit_done, 0);
        chk("t5_col_bo", balance_out, 50);
        tap(3);
        tick(3);
        chk("t5_after_fe", fund_enough, 0);
        chk("t5_after_bo", balance_out, 50);

        // Reset while waiting for a debit.
        admin(3, 1, 1000);
        tap(3);
        tick(3);
        chk("t6_rv", resp_valid, 1);
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("t6_ca", card_active, 0);
        chk("t6_bo", balance_out, 0);
        chk("t6_busy", busy, 0);
        tap(3);
        tick(3);
        chk("t6_cleared", card_active, 0);
`ifdef FARE_AUDIT_EN
        chk("t6_cnt0", debit_count, 0);
        admin(3, 1, 1000);
        for (int k = 0; k < 2; k++) begin
            tap(3);
            tick(3);
            pulse_reduce();
            tick(1);
        end
        chk("t6_cnt", debit_count, 2);
        chk("t6_rev", revenue, 630);
`endif
        tick(2);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
